// File: rtl/j1_dbus_uart_tx.sv
// rtl/j1_dbus_uart_tx.sv - J1 data-bus UART transmitter (TX FIFO, 8N1 framing)
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
module j1_dbus_uart_tx #(
    parameter logic [15:0] BASE_ADR       = 16'h7F00,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] m_dat_o,
    output logic [15:0] m_dat_i,
    output logic        txd,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_SUPPORT = 1'b1;
`else
    localparam logic PAR_SUPPORT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic        txd_q, txd_d;
    logic        irq_q, irq_d;
    logic [15:0] rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        hit, wr_hit, rd_hit, push_req, push, pop;
    logic        full, empty, tick;
    logic [7:0]  fifo_head;
    logic [15:0] status;

    assign hit      = (adr[15:2] == BASE_ADR[15:2]);
    assign wr_hit   = we && hit;
    assign rd_hit   = re && !we && hit;
    assign push_req = wr_hit && (adr[1:0] == 2'd0);

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head = mem_q[rd_ptr_q[AW-1:0]];
    assign tick      = (cnt_q == 16'd0);

    // A full FIFO still accepts a byte when the shifter drains one on the same edge.
    assign push   = push_req && (!full || pop);
    assign status = {11'd0, PAR_SUPPORT, ovf_q, (state_q != S_IDLE), empty, full};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = tick ? div_q : (cnt_q - 1'b1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_head;
`endif
                    state_d = S_START;
                    cnt_d   = div_q;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_head;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // txd and irq are derived from next-state so they move on the same edge as the FSM.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        irq_d = (wr_ptr_d == rd_ptr_d) && (state_d == S_IDLE);
    end

    always_comb begin
        div_d   = div_q;
        ovf_d   = ovf_q;
        rdata_d = 16'd0;
        if (wr_hit && (adr[1:0] == 2'd2)) div_d = m_dat_o;
        if (rd_hit) begin
            case (adr[1:0])
                2'd1: begin
                    rdata_d = status;
                    ovf_d   = 1'b0;
                end
                2'd2:    rdata_d = div_q;
                default: rdata_d = 16'd0;
            endcase
        end
        if (push_req && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= m_dat_o[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            cnt_q     <= 16'd0;
            div_q     <= BAUD_DIV_RESET;
            ovf_q     <= 1'b0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b1;
            rdata_q   <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign m_dat_i = rdata_q;
    assign txd     = txd_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_j1_dbus_uart_tx.sv
// tb/tb_j1_dbus_uart_tx.sv - self-checking bench for j1_dbus_uart_tx
module tb_j1_dbus_uart_tx;

    localparam logic [15:0] BASE  = 16'h7F00;
    localparam int          DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [15:0] PARF = 16'h0010;
`else
    localparam int          NB   = 10;
    localparam logic [15:0] PARF = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] adr = 16'h0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] m_dat_o = 16'h0;
    logic [15:0] m_dat_i;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit zchk_en  = 1'b0;
    logic rd_exp;

    j1_dbus_uart_tx #(
        .BASE_ADR(BASE),
        .FIFO_DEPTH(DEPTH),
        .BAUD_DIV_RESET(16'd867)
    ) dut (
        .clk(clk),
        .reset(reset),
        .adr(adr),
        .re(re),
        .we(we),
        .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i),
        .txd(txd),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Read data must be zero in every cycle that does not follow a hit read.
    always @(posedge clk) begin
        rd_exp = reset && re && !we && ((adr >> 2) == (BASE >> 2));
        #1;
        if (zchk_en && !rd_exp) begin
            n_checks++;
            if (m_dat_i !== 16'h0) begin
                n_fail++;
                $display("FAIL idle_rdata: m_dat_i=%h required 0000", m_dat_i);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        adr = a; m_dat_o = d; we = 1'b1;
        step();
        we = 1'b0; adr = 16'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        adr = a; re = 1'b1;
        step();
        re = 1'b0; adr = 16'h0;
        d = m_dat_i;
    endtask

    // Line-level receiver: every cycle of every bit must hold its level and irq must stay low.
    task automatic rx_byte(input int div, input int timeout,
                           output logic [7:0] b, output bit err, output int gap);
        logic lvl;
        err = 1'b0; b = 8'h0; gap = 0;
        while (txd !== 1'b0 && gap < timeout) begin
            step();
            gap++;
        end
        if (txd !== 1'b0) begin
            err = 1'b1;
            return;
        end
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c <= div; c++) begin
                lvl = txd;
                if (k == 0) begin
                    if (lvl !== 1'b0) err = 1'b1;
                end else if (k <= 8) begin
                    if (c == 0) b[k-1] = lvl;
                    else if (lvl !== b[k-1]) err = 1'b1;
                end else if (k == NB - 1) begin
                    if (lvl !== 1'b1) err = 1'b1;
                end else begin
                    if (lvl !== ^b) err = 1'b1;
                end
                if (irq !== 1'b0) err = 1'b1;
                step();
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b0;
        step(); step();
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", txd); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b required 1", irq); end
        n_checks++; if (m_dat_i !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0000", m_dat_i); end
        reset = 1'b1;
        zchk_en = 1'b1;
        bus_read(BASE + 16'd2, d);
        n_checks++; if (d !== 16'd867) begin n_fail++; $display("FAIL reset_baud: got %0d required 867", d); end
        bus_read(BASE + 16'd1, d);
        n_checks++; if (d !== (16'h0002 | PARF)) begin n_fail++; $display("FAIL reset_status: got %h required %h", d, 16'h0002 | PARF); end
    endtask

    task automatic test_single_frame();
        logic [7:0] b; bit err; int gap;
        bus_write(BASE + 16'd2, 16'd3);
        bus_write(BASE, 16'h00A5);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_low: got %b required 0", irq); end
        rx_byte(3, 50, b, err, gap);
        n_checks++; if (gap !== 1) begin n_fail++; $display("FAIL single_latency: got %0d required 1", gap); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_frame_shape: got err=%b required 0", err); end
        n_checks++; if (b !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %h required a5", b); end
        n_checks++; if (irq !== 1'b1 || txd !== 1'b1) begin n_fail++; $display("FAIL single_done: got irq=%b txd=%b required 1 1", irq, txd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b; bit err; int gap;
        bus_write(BASE + 16'd2, 16'd0);
        bus_write(BASE, 16'h0055);
        bus_write(BASE, 16'h000F);
        rx_byte(0, 10, b, err, gap);
        n_checks++; if (err !== 1'b0 || b !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got %h err=%b required 55 err=0", b, err); end
        rx_byte(0, 10, b, err, gap);
        n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles required 0", gap); end
        n_checks++; if (err !== 1'b0 || b !== 8'h0F) begin n_fail++; $display("FAIL b2b_second: got %h err=%b required 0f err=0", b, err); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq: got %b required 1", irq); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes_q [$];
        logic [15:0] d;
        logic [7:0] hi, lo, b;
        bit err, quiet; int gap;
        bus_write(BASE + 16'd2, 16'd100);
        for (int i = 0; i < DEPTH + 2; i++) begin
            lo = 8'($urandom_range(0, 255));
            bytes_q.push_back(lo);
        end
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) begin
                    hi = 8'($urandom_range(0, 255));
                    bus_write(BASE, {hi, bytes_q[i]});
                end
                bus_read(BASE + 16'd1, d);
                n_checks++; if (d !== (16'h000D | PARF)) begin n_fail++; $display("FAIL ovf_status1: got %h required %h", d, 16'h000D | PARF); end
                bus_read(BASE + 16'd1, d);
                n_checks++; if (d !== (16'h0005 | PARF)) begin n_fail++; $display("FAIL ovf_status2: got %h required %h", d, 16'h0005 | PARF); end
            end
            begin
                // The first byte moves straight into the shifter, so DEPTH more fit behind it.
                for (int i = 0; i < DEPTH + 1; i++) begin
                    rx_byte(100, 2000, b, err, gap);
                    n_checks++;
                    if (err !== 1'b0 || b !== bytes_q[i] || (i > 0 && gap != 0)) begin
                        n_fail++;
                        $display("FAIL ovf_rx[%0d]: got %h err=%b gap=%0d required %h err=0", i, b, err, gap, bytes_q[i]);
                    end
                end
            end
        join
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (txd !== 1'b1 || irq !== 1'b1) quiet = 1'b0;
            step();
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL ovf_dropped: got extra activity required idle line"); end
        bus_read(BASE + 16'd1, d);
        n_checks++; if (d !== (16'h0002 | PARF)) begin n_fail++; $display("FAIL ovf_final_status: got %h required %h", d, 16'h0002 | PARF); end
    endtask

    task automatic test_decode();
        logic [15:0] d;
        bus_read(BASE + 16'd3, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL dec_reserved: got %h required 0000", d); end
        bus_read(BASE + 16'd4, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL dec_outside: got %h required 0000", d); end
        bus_read(BASE, d);
        n_checks++; if (d !== 16'h0) begin n_fail++; $display("FAIL dec_txdata_read: got %h required 0000", d); end
        bus_write(BASE - 16'd1, 16'h0011);
        bus_write(BASE + 16'd3, 16'h0022);
        step();
        n_checks++; if (irq !== 1'b1 || txd !== 1'b1) begin n_fail++; $display("FAIL dec_miss_write: got irq=%b txd=%b required 1 1", irq, txd); end
        bus_read(BASE + 16'd1, d);
        n_checks++; if (d !== (16'h0002 | PARF)) begin n_fail++; $display("FAIL dec_status_empty: got %h required %h", d, 16'h0002 | PARF); end
        adr = BASE + 16'd2; m_dat_o = 16'h0007; re = 1'b1; we = 1'b1;
        step();
        re = 1'b0; we = 1'b0; adr = 16'h0;
        n_checks++; if (m_dat_i !== 16'h0) begin n_fail++; $display("FAIL dec_re_we_rdata: got %h required 0000", m_dat_i); end
        bus_read(BASE + 16'd2, d);
        n_checks++; if (d !== 16'h0007) begin n_fail++; $display("FAIL dec_re_we_write: got %h required 0007", d); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [15:0] d, div;
        logic [7:0] b, hi;
        bit err; int gap, n;
        for (int r = 0; r < 4; r++) begin
            div = 16'($urandom_range(0, 4));
            bus_write(BASE + 16'd2, div);
            bus_read(BASE + 16'd2, d);
            n_checks++; if (d !== div) begin n_fail++; $display("FAIL rnd_baud[%0d]: got %h required %h", r, d, div); end
            n = $urandom_range(1, 6);
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        hi = 8'($urandom_range(0, 255));
                        bus_write(BASE, {hi, exp_q[i]});
                        repeat ($urandom_range(0, 3)) step();
                    end
                end
                begin
                    for (int i = 0; i < n; i++) begin
                        rx_byte(int'(div), 200, b, err, gap);
                        n_checks++;
                        if (err !== 1'b0 || b !== exp_q[i]) begin
                            n_fail++;
                            $display("FAIL rnd_rx[%0d.%0d]: got %h err=%b required %h err=0", r, i, b, err, exp_q[i]);
                        end
                    end
                end
            join
            n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b required 1", r, irq); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        bit quiet; int n;
        bus_write(BASE + 16'd2, 16'd3);
        bus_write(BASE, 16'h00A5);
        bus_write(BASE, 16'h003C);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin step(); n++; end
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rmf_start: got txd=%b required 0", txd); end
        // Start bit plus three data bits span 16 cycles; one more lands inside bit 3.
        repeat (17) step();
        reset = 1'b0;
        step();
        n_checks++; if (txd !== 1'b1 || irq !== 1'b1 || m_dat_i !== 16'h0) begin n_fail++; $display("FAIL rmf_reset: got txd=%b irq=%b rdata=%h required 1 1 0000", txd, irq, m_dat_i); end
        reset = 1'b1;
        step();
        bus_read(BASE + 16'd1, d);
        n_checks++; if (d !== (16'h0002 | PARF)) begin n_fail++; $display("FAIL rmf_status: got %h required %h", d, 16'h0002 | PARF); end
        quiet = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (txd !== 1'b1) quiet = 1'b0;
            step();
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rmf_no_frame: got line activity required idle"); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_decode();
        test_random();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j1_dbus_uart_tx.md
Name: j1_dbus_uart_tx

Overview:
- Memory-mapped UART transmitter that is the responder (slave) on the J1 data bus.
- The core issues a single-cycle `re`/`we` strobe and samples read data on the following cycle.
  - This block decodes the word address.
  - It queues written bytes in a TX FIFO.
  - It serialises them 8N1 (optionally 8E1) on `txd`.
- Sits beside data RAM in the SoC top, behind the dbus read-data mux.

Parameters:
- BASE_ADR, 16'h7F00, word address of register 0; registers occupy BASE_ADR..BASE_ADR+3.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..64.
- BAUD_DIV_RESET, 16'd867, reset value of the divisor; bit period = divisor+1 clk cycles.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- dbus  if_dbus.slave  -  data bus responder:
  - adr in [15:0], word address.
  - re in 1.
  - we in 1.
  - m_dat_o in [15:0], write data from the core.
  - m_dat_i out [15:0], read data to the core.
- txd  output  1  serial line; idle high.
- irq  output  1  level; high while the FIFO is empty and the shifter is idle (transmit complete).

Behaviour:
- Reset (reset==0 at a clk edge), taking effect on that edge even mid-frame:
  - txd=1, irq=1, m_dat_i=0.
  - FIFO emptied.
  - FSM=IDLE.
  - divisor=BAUD_DIV_RESET.
  - overflow=0.
- Hit: adr[15:2]==BASE_ADR[15:2]. Register offset = adr[1:0].
  - 0 TXDATA: W, pushes m_dat_o[7:0]. R returns 0.
  - 1 STATUS: R only.
    - [0] full, [1] empty, [2] busy (FSM!=IDLE), [3] overflow (sticky), [15:4]=0.
    - A read clears overflow on the same edge that captures it.
  - 2 BAUD: RW, 16-bit divisor.
  - 3: reserved; reads 0, writes ignored.
- Read latency exactly 1:
  - re && hit in cycle N → m_dat_i holds the register value during cycle N+1.
  - In all other cycles m_dat_i is registered 0, so a top-level OR-mux is legal.
- Writes take effect at the clk edge ending the we cycle.
- re and we are never both high; if they are, the write takes effect and m_dat_i=0.
- No wait states; the slave never stalls.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; pointer wrap is natural modulo.
  - full = MSBs differ and the rest of the pointer bits are equal.
  - empty = pointers equal.
  - Push when full and no pop in the same cycle: byte dropped, overflow set.
  - Push when full with a simultaneous pop: accepted.
  - Push while empty and IDLE: the byte is popped the next cycle.
- Baud counter: counts down from divisor to 0.
  - tick at 0, then reloads.
  - Reloads at frame start, so the first start bit lasts exactly divisor+1 cycles.
  - Divisor write mid-frame applies at the next reload.
  - Divisor 0 gives a 1-cycle bit.
- FSM:
  - IDLE: txd=1. When !empty: pop into shift register, go START, reload counter.
  - START: txd=0 for one bit period, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Shift on tick; after bit index 7 go PARITY if enabled, else STOP.
  - PARITY (optional): txd = XOR of the 8 data bits, one bit period, then STOP.
  - STOP: txd=1 for one bit period.
    - If !empty at tick: pop and go directly to START (back-to-back frames, no idle gap).
    - Else go IDLE.
- txd is a registered output, so the line changes exactly on bit boundaries.
- irq = empty && FSM==IDLE, registered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state present; frame = 11 bits (8E1, even parity).
  - STATUS[4]=1 advertises parity support.
- Undefined:
  - PARITY state and logic absent; frame = 10 bits (8N1).
  - STATUS[4]=0.

Test Plan:
- Reset check: hold reset=0 for 2 cycles → txd=1, irq=1, m_dat_i=0. Read BAUD (adr=BASE_ADR+2) → m_dat_i=867 the cycle after re.
- Single frame: write BAUD=3, then TXDATA=16'h00A5 → txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high.
  - Without parity: irq rises after 40 cycles of frame.
  - With parity: parity bit 0, 44 cycles.
- Back-to-back: BAUD=0, write 16'h55 then 16'h0F in consecutive we cycles → two frames with no idle cycle between the stop bit and the next start bit.
- Overflow: BAUD=100, write 1+FIFO_DEPTH+1 bytes in consecutive cycles.
  - STATUS reads [0]=1, [3]=1.
  - A second STATUS read returns [3]=0.
  - Only the first 1+FIFO_DEPTH bytes appear on txd.
- Decode/latency:
  - re at BASE_ADR+3 and at BASE_ADR+4 → m_dat_i=0.
  - we at BASE_ADR-1 → FIFO stays empty (STATUS[1]=1).
  - m_dat_i=0 in every cycle not following a hit read.
- Reset mid-frame: reset=0 during DATA bit 3 → txd=1 on the next edge, FIFO empty, no further frame after reset is released.
